// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//
// Contents:
//   WIDTH_DEF - default operand / HI / LO width
//   op_e      - operation encoding as presented on op_i
//   state_e   - sequencer FSM states
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  // Operation codes as delivered by the EX stage decoder.
  // Bit 1 selects divide and bit 0 selects unsigned.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // IDLE waits for work, RUN iterates one bit per cycle,
  // SIGN applies the sign fixup and commits HI/LO.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SIGN = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// Single-iteration combinational datapath shared by multiply and divide.
//
// Ports:
//   isDiv_i   - 1: restoring divide step, 0: shift-add multiply step
//   acc_i     - current 2*WIDTH accumulator
//                 multiply: {partial product high, remaining multiplier bits}
//                 divide:   {partial remainder, remaining dividend / quotient bits}
//   operand_i - multiplicand (multiply) or divisor (divide) magnitude
//   acc_o     - accumulator after one iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 isDiv_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remDiff;
  logic             fits;

  // Multiply: add the multiplicand into the top half when the current
  // multiplier LSB is set, then shift the whole accumulator right with the
  // carry entering at the top.
  // Divide: shift the accumulator left by one, trial-subtract the divisor
  // from the widened partial remainder and keep the difference only if it
  // did not go negative; the quotient bit enters at the bottom.
  // The shifted remainder is always below twice the divisor, so when the
  // subtraction succeeds the difference fits in WIDTH bits and can be
  // computed modulo 2^WIDTH.
  always_comb begin
    mulSum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    remShift = acc_i[2*WIDTH-1:WIDTH-1];
    remDiff  = remShift[WIDTH-1:0] - operand_i;
    fits     = (remShift >= {1'b0, operand_i});
    if (isDiv_i) begin
      acc_o = {(fits ? remDiff : remShift[WIDTH-1:0]), acc_i[WIDTH-2:0], fits};
    end else begin
      acc_o = {mulSum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller for the EX stage; owns HI/LO.
//
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   start_i       - EX holds a mult/div instruction
//   op_i          - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_i, rt_i    - forwarded operands (rs is also the MTHI/MTLO data)
//   mf_req_i      - EX holds MFHI/MFLO
//   mthi_i/mtlo_i - EX holds MTHI/MTLO
//   flush_i       - EX is being flushed; blocks acceptance and MT writes
//   hi_o, lo_o    - HI/LO registers
//   busy_o        - operation in progress (registered)
//   stall_o       - ALU_stall to the hazard unit
//
// Signed operations run on magnitudes and the signs are restored in SIGN,
// so every non-trivial operation takes the same number of cycles.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6            // needs 2**CNT_W > WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             mf_req_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             stall_o
);

  state_e             state_q;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               negRes_q;
  logic               negRem_q;

  op_e                opIn;
  logic               signedIn;
  logic               divIn;
  logic               rsNeg;
  logic               rtNeg;
  logic [WIDTH-1:0]   rsMag;
  logic [WIDTH-1:0]   rtMag;
  logic               accept;
  logic               divZero;

  logic               divQ;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  // Decode the incoming request and form operand magnitudes. For signed ops
  // the most negative value negates onto itself, which is still the correct
  // unsigned magnitude, so no special case is needed.
  always_comb begin
    opIn     = op_e'(op_i);
    signedIn = (opIn == OP_MULT) || (opIn == OP_DIV);
    divIn    = (opIn == OP_DIV) || (opIn == OP_DIVU);
    rsNeg    = signedIn & rs_i[WIDTH-1];
    rtNeg    = signedIn & rt_i[WIDTH-1];
    rsMag    = rsNeg ? (~rs_i + 1'b1) : rs_i;
    rtMag    = rtNeg ? (~rt_i + 1'b1) : rt_i;
    accept   = start_i & ~flush_i & ~busy_q;
    divZero  = divIn & (rt_i == '0);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .isDiv_i   (divQ),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (acc_d)
  );

  // Sign fixup applied in SIGN. A product is negated as one 2*WIDTH value;
  // a quotient and remainder are negated independently, the remainder
  // following the dividend's sign.
  always_comb begin
    divQ    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    prodFix = negRes_q ? (~acc_q + 1'b1) : acc_q;
    if (divQ) begin
      hi_d = negRem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      lo_d = negRes_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end else begin
      hi_d = prodFix[2*WIDTH-1:WIDTH];
      lo_d = prodFix[WIDTH-1:0];
    end
  end

  // Sequencer FSM. HI/LO change only on MT writes while idle or in SIGN,
  // so MFHI/MFLO issued before an operation completes see the old values.
  // A divide by zero skips RUN and commits HI=rs, LO=all-ones through SIGN
  // with the sign flags cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flush_i) begin
            if (mthi_i) hi_q <= rs_i;
            if (mtlo_i) lo_q <= rs_i;
          end
          if (accept) begin
            op_q   <= opIn;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (divZero) begin
              acc_q    <= {rs_i, {WIDTH{1'b1}}};
              opnd_q   <= '0;
              negRes_q <= 1'b0;
              negRem_q <= 1'b0;
              state_q  <= SIGN;
            end else begin
              acc_q    <= divIn ? {{WIDTH{1'b0}}, rsMag} : {{WIDTH{1'b0}}, rtMag};
              opnd_q   <= divIn ? rtMag : rsMag;
              negRes_q <= rsNeg ^ rtNeg;
              negRem_q <= rsNeg;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = busy_q;
  assign stall_o = busy_q & (start_i | mf_req_i | mthi_i | mtlo_i);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised self-checking bench for muldiv_sequencer. Expected HI/LO come
// from plain 64-bit arithmetic; timing expectations come from the
// documented accept/RUN/SIGN latency.
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        mf_req_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic        flush_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        stall_o;

  int numCompared   = 0;
  int numMismatched = 0;

  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  muldiv_sequencer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .mf_req_i (mf_req_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .flush_i  (flush_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // A start together with an MT write is an illegal stimulus combination.
  always @(posedge clk_i) begin
    assert (!(start_i && (mthi_i || mtlo_i)))
      else $error("[TB] illegal start_i together with mthi_i/mtlo_i");
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Architectural result of one MIPS mult/div operation.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; {hi, lo} = p; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Follows an operation cycle by cycle from T1 until busy drops, checking
  // the stall output each cycle and that HI/LO still hold the old values
  // mid-run. mf_req_i is raised from T3 when holdMf is set.
  task automatic runToDone(input bit holdMf, input bit holdStart, input int expBusy);
    int t;
    t = 1;
    while (busy_o && t < 200) begin
      if (holdMf && t >= 3) mf_req_i = 1'b1;
      #1;
      checkOutput("stallRun", stall_o, holdStart || (holdMf && t >= 3));
      if (t == 5) begin
        checkOutput("hiHeld", hi_o, modelHi);
        checkOutput("loHeld", lo_o, modelLo);
      end
      t++;
      @(negedge clk_i);
    end
    checkOutput("busyLen", t - 1, expBusy);
    if (holdMf) begin
      #1;
      checkOutput("stallEnd", stall_o, 0);
      mf_req_i = 1'b0;
    end
  endtask

  // Issues one mult/div in cycle T0 and checks it through to completion.
  // holdStart keeps the instruction asserted while busy so it must be
  // stalled and then re-accepted once busy drops.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit holdMf,
                               input bit holdStart);
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
    refModel(op, a, b, expHi, expLo);
    expBusy = (op[1] && b == 0) ? 1 : 33;
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    rs_i    = a;
    rt_i    = b;
    #1;
    checkOutput("busyT0", busy_o, 0);
    checkOutput("stallT0", stall_o, 0);
    @(negedge clk_i);
    if (!holdStart) begin
      start_i = 1'b0;
      rs_i    = $urandom;
      rt_i    = $urandom;
    end
    checkOutput("busyT1", busy_o, 1);
    runToDone(holdMf, holdStart, expBusy);
    checkOutput("hiResult", hi_o, expHi);
    checkOutput("loResult", lo_o, expLo);
    modelHi = expHi;
    modelLo = expLo;
    if (holdStart) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checkOutput("busyRelaunch", busy_o, 1);
      runToDone(1'b0, 1'b0, expBusy);
      checkOutput("hiRelaunch", hi_o, expHi);
      checkOutput("loRelaunch", lo_o, expLo);
    end
  endtask

  // One-cycle MTHI/MTLO, optionally flushed.
  task automatic applyMove(input bit toHi, input bit toLo, input bit flush,
                           input logic [31:0] data);
    @(negedge clk_i);
    mthi_i  = toHi;
    mtlo_i  = toLo;
    flush_i = flush;
    rs_i    = data;
    @(negedge clk_i);
    mthi_i  = 1'b0;
    mtlo_i  = 1'b0;
    flush_i = 1'b0;
    if (!flush) begin
      if (toHi) modelHi = data;
      if (toLo) modelLo = data;
    end
    checkOutput("hiMove", hi_o, modelHi);
    checkOutput("loMove", lo_o, modelLo);
  endtask

  function automatic logic [31:0] pickOperand(input bit allowZero);
    int unsigned sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return allowZero ? 32'h0 : 32'h1;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Main sequence: reset, directed cases, reset abort, then random traffic.
  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b0;
    op_i     = 2'b00;
    rs_i     = '0;
    rt_i     = '0;
    mf_req_i = 1'b0;
    mthi_i   = 1'b0;
    mtlo_i   = 1'b0;
    flush_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rstHi", hi_o, 0);
    checkOutput("rstLo", lo_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstStall", stall_o, 0);

    applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    checkOutput("multNegHi", hi_o, 32'hFFFF_FFFF);
    checkOutput("multNegLo", lo_o, 32'hFFFF_FFEB);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("multuMaxHi", hi_o, 32'hFFFF_FFFE);
    checkOutput("multuMaxLo", lo_o, 32'h0000_0001);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    checkOutput("divNegLo", lo_o, 32'hFFFF_FFFD);
    checkOutput("divNegHi", hi_o, 32'hFFFF_FFFF);
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    checkOutput("divuLo", lo_o, 32'd14);
    checkOutput("divuHi", hi_o, 32'd2);
    applyStimulus(2'b11, 32'h1234, 32'd0, 1'b0, 1'b0);
    checkOutput("divZeroHi", hi_o, 32'h1234);
    checkOutput("divZeroLo", lo_o, 32'hFFFF_FFFF);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("divOvfLo", lo_o, 32'h8000_0000);
    checkOutput("divOvfHi", hi_o, 32'h0);
    applyStimulus(2'b00, 32'h0001_2345, 32'hFFF0_0001, 1'b1, 1'b0);
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b1);

    // A flushed start must not be accepted.
    @(negedge clk_i);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 2'b00;
    rs_i    = 32'd9;
    rt_i    = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    checkOutput("flushBusy", busy_o, 0);
    checkOutput("flushHi", hi_o, modelHi);

    applyMove(1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
    applyMove(1'b0, 1'b1, 1'b0, 32'h5A5A_0002);
    applyMove(1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD);
    applyMove(1'b1, 1'b1, 1'b0, 32'h1357_9BDF);

    // Reset in T10 of a divide aborts it and clears HI/LO.
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 2'b10;
    rs_i    = 32'd1000;
    rt_i    = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    checkOutput("busyT10", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("abortBusy", busy_o, 0);
    checkOutput("abortHi", hi_o, 0);
    checkOutput("abortLo", lo_o, 0);
    modelHi = '0;
    modelLo = '0;
    applyStimulus(2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
    checkOutput("mult35Lo", lo_o, 32'd15);
    checkOutput("mult35Hi", hi_o, 32'd0);

    // Random traffic with corner-biased operands and occasional MT writes.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyMove(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom);
      end
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(1'b1), pickOperand(1'b1),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
